div_ratio_meter: RTL and testbench
==================================

Name: div_ratio_meter

Overview:
- Receive-side companion to the clock dividers.
- Samples a divided clock or any periodic level signal in the `clk` domain.
- Measures its period and high time in `clk` cycles, and reports each completed measurement with a valid pulse.
- Flags lock when consecutive periods are stable, and flags timeout when the input stops toggling. Used to self-check divider outputs in-system.

Parameters:
- CNT_W, 16, width of period/high counters and result outputs.
- LOCK_CNT, 4, consecutive identical periods required to assert o_locked (range 2..15).
- TIMEOUT, 1024, `clk` cycles without a rising edge before timeout; must satisfy 2 <= TIMEOUT <= 2^CNT_W-1.

Ports:
- clk  input  1  measurement clock.
- rst  input  1  reset; synchronous, active-high.
- i_sig  input  1  signal under measurement; may be asynchronous to clk.
- o_period  output  CNT_W  last measured period in clk cycles.
- o_high  output  CNT_W  last measured high time in clk cycles.
- o_valid  output  1  one-cycle pulse; o_period/o_high updated this cycle.
- o_locked  output  1  LOCK_CNT consecutive equal periods seen.
- o_timeout  output  1  no rising edge for TIMEOUT cycles.

Behaviour:
- **Reset.** rst sampled on rising clk only. All outputs go to 0, the synchronizer/edge flops go to 0, state goes to IDLE, and all counters and the lock counter go to 0. Reset asserted mid-measurement discards the partial measurement; no o_valid is produced.
- **Input path.** 2-flop synchronizer s1→s2, then history flop s3. rise = s2 & ~s3. A clean input rise between clk edges is seen as rise two clk edges later.
- **IDLE.** Waits for rise. On rise: cnt<=1, hcnt<=1, o_timeout<=0, go to MEAS. No o_valid.
- **MEAS, each cycle.**
  - cnt<=cnt+1.
  - hcnt<=hcnt+1 while s2=1 and no fall has been seen since the last rise; frozen after the first fall.
- **MEAS, on rise.**
  - o_period<=cnt and o_high<=hcnt, with o_valid=1 the next cycle (registered).
  - Then cnt<=1, hcnt<=1, and the state stays in MEAS.
  - Rises spaced P cycles apart give o_period=P. High for H cycles gives o_high=H.
- **Lock.**
  - Compare the new period with the previous stored period. Equal: lock_cnt increments, saturating at LOCK_CNT-1. Unequal: lock_cnt<=0 and o_locked<=0.
  - o_locked<=1 when an equal comparison brings lock_cnt to LOCK_CNT-1, i.e. LOCK_CNT equal periods in a row.
  - The first measurement after IDLE has no previous period: lock_cnt<=0.
- **Timeout.**
  - In MEAS, when cnt reaches TIMEOUT and rise is not asserted in the same cycle: o_timeout<=1, o_locked<=0, lock_cnt<=0, go to IDLE, no o_valid.
  - o_timeout holds until the next rise.
  - A rise in the same cycle as cnt==TIMEOUT counts as a valid measurement; the rise wins.
- **Counter widths.** cnt never exceeds TIMEOUT, so no overflow or wrap logic is needed.
- **Constant input.** A constant-high input never produces a rise after the first one. hcnt stops at TIMEOUT-equivalent values, and the timeout path applies.
- **Fast toggling.** Minimum measurable period is 2 (input toggling every clk, synchronous): o_period=2, o_high=1.
- **Latency.** Input rise to o_valid is 3 clk when the input is synchronous to clk.

Optional Feature:
- Macro: DUTY_FLAG_EN.
- Defined:
  - Adds output port o_duty_ok (1 bit, reset 0), updated with o_valid.
  - o_duty_ok=1 when |2*o_high - o_period| <= 1, computed at CNT_W+1 bits; otherwise 0.
  - Cleared on timeout.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- rst high 3 cycles mid-activity, then low with i_sig=0 → all outputs 0, no o_valid for 10 cycles.
- i_sig driven synchronously, toggling every clk (div-by-2 pattern), 10 periods → o_valid every 2 cycles, o_period=2, o_high=1, o_locked=1 from the 4th valid onward.
- i_sig period 10, high 3, then switch to period 12, high 6 → valids report 10/3, then 12/6. o_locked drops on the first 12 and reasserts after 4 equal 12s. With DUTY_FLAG_EN, o_duty_ok is 0 for 10/3 and 1 for 12/6.
- TIMEOUT=64 and i_sig stuck at 1 after lock → o_timeout=1 and o_locked=0 exactly 64 cycles after the last rise-reset of cnt. Next rise clears o_timeout with no o_valid; the second rise gives o_valid.
- Rise coincident with cnt==TIMEOUT (period exactly 64) → o_valid with o_period=64 and o_timeout stays 0.
- rst pulsed for 1 cycle mid-period while locked → o_locked=0, the state returns to IDLE, and the first rise after reset produces no o_valid.

Source files
------------

// File: rtl/div_ratio_meter.sv
// rtl/div_ratio_meter.sv - period/high-time meter with lock and timeout flags for divided clocks
// Optional feature macro: DUTY_FLAG_EN (adds o_duty_ok, ~50% duty indication)
module div_ratio_meter #(
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sig,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_valid,
    output logic             o_locked,
`ifdef DUTY_FLAG_EN
    output logic             o_duty_ok,
`endif
    output logic             o_timeout
);

    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_MEAS  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TMO  = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LOCK_MAX = 4'(LOCK_CNT - 1);

    logic             s1, s2, s3;
    logic             rise;
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt, hcnt;
    logic             fall_seen;
    logic             have_prev;
    logic [3:0]       lock_cnt;

    assign rise = s2 & ~s3;

`ifdef DUTY_FLAG_EN
    // Duty is judged on the counts about to be published, one extra bit so 2*high cannot wrap.
    logic [CNT_W:0] dbl_high, per_ext, duty_diff;
    logic           duty_ok_next;

    always_comb begin
        dbl_high     = {hcnt, 1'b0};
        per_ext      = {1'b0, cnt};
        duty_diff    = (dbl_high >= per_ext) ? (dbl_high - per_ext) : (per_ext - dbl_high);
        duty_ok_next = (duty_diff <= (CNT_W+1)'(1));
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            state     <= ST_IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            fall_seen <= 1'b0;
            have_prev <= 1'b0;
            lock_cnt  <= '0;
            o_period  <= '0;
            o_high    <= '0;
            o_valid   <= 1'b0;
            o_locked  <= 1'b0;
            o_timeout <= 1'b0;
`ifdef DUTY_FLAG_EN
            o_duty_ok <= 1'b0;
`endif
        end else begin
            s1      <= i_sig;
            s2      <= s1;
            s3      <= s2;
            o_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        cnt       <= CNT_ONE;
                        hcnt      <= CNT_ONE;
                        fall_seen <= 1'b0;
                        have_prev <= 1'b0;
                        o_timeout <= 1'b0;
                        state     <= ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    if (rise) begin
                        o_period  <= cnt;
                        o_high    <= hcnt;
                        o_valid   <= 1'b1;
                        cnt       <= CNT_ONE;
                        hcnt      <= CNT_ONE;
                        fall_seen <= 1'b0;
                        have_prev <= 1'b1;
`ifdef DUTY_FLAG_EN
                        o_duty_ok <= duty_ok_next;
`endif
                        // o_period still holds the previous measurement here.
                        if (!have_prev) begin
                            lock_cnt <= '0;
                        end else if (cnt == o_period) begin
                            if (lock_cnt != LOCK_MAX)
                                lock_cnt <= lock_cnt + 4'd1;
                            if (lock_cnt >= LOCK_MAX - 4'd1)
                                o_locked <= 1'b1;
                        end else begin
                            lock_cnt <= '0;
                            o_locked <= 1'b0;
                        end
                    end else if (cnt == CNT_TMO) begin
                        o_timeout <= 1'b1;
                        o_locked  <= 1'b0;
                        lock_cnt  <= '0;
                        have_prev <= 1'b0;
                        state     <= ST_IDLE;
`ifdef DUTY_FLAG_EN
                        o_duty_ok <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        if (s2 && !fall_seen)
                            hcnt <= hcnt + CNT_ONE;
                        if (!s2)
                            fall_seen <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ratio_meter.sv
// tb/tb_div_ratio_meter.sv - scoreboard bench for div_ratio_meter
module tb_div_ratio_meter;

    localparam int CNT_W    = 16;
    localparam int LOCK_CNT = 4;
    localparam int TIMEOUT  = 64;

    typedef struct {
        int p;
        int h;
        int n;
        bit duty;
    } seg_t;

    typedef struct {
        int period;
        int high;
        bit locked;
        bit duty;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             i_sig;
    logic [CNT_W-1:0] o_period;
    logic [CNT_W-1:0] o_high;
    logic             o_valid;
    logic             o_locked;
    logic             o_timeout;
    logic             o_duty_ok;

    div_ratio_meter #(
        .CNT_W   (CNT_W),
        .LOCK_CNT(LOCK_CNT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_sig    (i_sig),
        .o_period (o_period),
        .o_high   (o_high),
        .o_valid  (o_valid),
        .o_locked (o_locked),
`ifdef DUTY_FLAG_EN
        .o_duty_ok(o_duty_ok),
`endif
        .o_timeout(o_timeout)
    );

`ifndef DUTY_FLAG_EN
    assign o_duty_ok = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 0;
    exp_t sb[$];

    // Reference model of what the meter should report for the waveform being driven.
    bit m_meas = 0;
    bit m_have_prev = 0;
    int m_p = 0, m_h = 0, m_prev = 0, m_run = 0;
    bit m_duty = 0, m_lk = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_idle();
        m_meas      = 0;
        m_have_prev = 0;
        m_run       = 0;
        m_lk        = 0;
    endtask

    task automatic do_rise(input int p, input int h, input bit duty);
        if (m_meas) begin
            if (!m_have_prev) begin
                m_run = 0;
            end else if (m_p == m_prev) begin
                if (m_run < LOCK_CNT - 1) m_run++;
                if (m_run == LOCK_CNT - 1) m_lk = 1;
            end else begin
                m_run = 0;
                m_lk  = 0;
            end
            m_have_prev = 1;
            m_prev      = m_p;
            sb.push_back('{m_p, m_h, m_lk, m_duty});
        end
        m_meas = 1;
        m_p    = p;
        m_h    = h;
        m_duty = duty;
        i_sig  = 1'b1;
    endtask

    // Called on a negedge; returns on the negedge that ends the period.
    task automatic drive_period(input int p, input int h, input bit duty);
        do_rise(p, h, duty);
        repeat (h) @(negedge clk);
        i_sig = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    // Same as drive_period (h >= 3) but also checks o_valid/o_timeout on the 3 edges after the rise.
    task automatic rise_checked(input int p, input int h, input bit duty,
                                input bit exp_v3, input bit to_before, input bit to_after);
        do_rise(p, h, duty);
        @(posedge clk); #1;
        check("lat_valid_e1", o_valid, 0);
        check("lat_timeout_e1", o_timeout, to_before);
        @(posedge clk); #1;
        check("lat_valid_e2", o_valid, 0);
        check("lat_timeout_e2", o_timeout, to_before);
        @(posedge clk); #1;
        check("lat_valid_e3", o_valid, exp_v3);
        check("lat_timeout_e3", o_timeout, to_after);
        @(negedge clk);
        repeat (h - 3) @(negedge clk);
        i_sig = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en && o_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("period", o_period, e.period);
                check("high", o_high, e.high);
                check("locked", o_locked, e.locked);
`ifdef DUTY_FLAG_EN
                check("duty_ok", o_duty_ok, e.duty);
`endif
            end
        end
    end

    seg_t segs[3];

    initial begin
        segs[0] = '{2, 1, 10, 1};
        segs[1] = '{10, 3, 6, 0};
        segs[2] = '{12, 6, 6, 1};

        rst   = 1'b1;
        i_sig = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            i_sig = 1'($urandom_range(0, 1));
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            i_sig = 1'($urandom_range(0, 1));
        end
        rst    = 1'b0;
        i_sig  = 1'b0;
        mon_en = 1;
        @(posedge clk); #1;
        check("rst_period", o_period, 0);
        check("rst_high", o_high, 0);
        check("rst_valid", o_valid, 0);
        check("rst_locked", o_locked, 0);
        check("rst_timeout", o_timeout, 0);
        check("rst_duty", o_duty_ok, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_no_valid", o_valid, 0);
        end
        @(negedge clk);

        foreach (segs[s])
            for (int k = 0; k < segs[s].n; k++)
                drive_period(segs[s].p, segs[s].h, segs[s].duty);

        // Stuck high after lock: timeout exactly TIMEOUT cycles after cnt restarts.
        do_rise(0, 0, 0);
        repeat (TIMEOUT + 2) @(posedge clk);
        #1;
        check("timeout_early", o_timeout, 0);
        @(posedge clk); #1;
        check("timeout_set", o_timeout, 1);
        check("timeout_locked", o_locked, 0);
        check("timeout_valid", o_valid, 0);
        model_idle();
        @(negedge clk);
        i_sig = 1'b0;
        repeat (5) @(negedge clk);
        check("timeout_hold", o_timeout, 1);

        rise_checked(8, 4, 1, 0, 1, 0);
        rise_checked(8, 4, 1, 1, 0, 0);

        // Period exactly TIMEOUT: rise coincides with cnt==TIMEOUT and must win.
        for (int k = 0; k < 3; k++) drive_period(TIMEOUT, TIMEOUT / 2, 1);
        check("edge_no_timeout", o_timeout, 0);
        for (int k = 0; k < 6; k++) drive_period(6, 3, 1);

        // One-cycle reset mid-period while locked.
        do_rise(6, 3, 1);
        repeat (3) @(negedge clk);
        check("pre_rst_locked", o_locked, 1);
        rst   = 1'b1;
        i_sig = 1'b0;
        model_idle();
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_locked", o_locked, 0);
        check("mid_rst_period", o_period, 0);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_timeout", o_timeout, 0);
        repeat (10) @(negedge clk);
        rise_checked(6, 3, 1, 0, 0, 0);
        drive_period(6, 3, 1);
        do_rise(6, 3, 1);
        repeat (6) @(negedge clk);
        i_sig = 1'b0;
        repeat (4) @(negedge clk);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
